// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
//
// Purpose:
//   An elastic pipeline stage register that uses a valid/ready handshake and
//   holds up to two entries. The main entry drives the downstream payload.
//   The skid entry catches the one payload that the upstream stage can still
//   push while the downstream stage stalls. Because in_ready_o and out_valid_o
//   are decoded only from registered state, the handshake has no
//   combinational path from one side to the other.
//
// Parameters:
//   WIDTH           payload width in bits
//   CLEAR_ON_FLUSH  1: payload registers are zeroed on flush
//                   0: payload registers keep their value on flush
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst          synchronous, active-high reset
//   flush_i      squash all buffered entries; drops the payload of this cycle
//   in_valid_i   upstream payload valid
//   in_ready_o   stage can accept a payload this cycle
//   in_data_i    upstream payload
//   out_valid_o  downstream payload valid
//   out_ready_i  downstream accepts the payload this cycle
//   out_data_o   downstream payload (the main entry)
//   occupancy_o  number of entries held: 0, 1 or 2
// -----------------------------------------------------------------------------
module pipe_skid_stage #(
  parameter int WIDTH          = 64,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       occupancy_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  logic in_fire;
  logic out_fire;

  // The handshakes depend only on registered state, so these fire terms never
  // feed back into in_ready_o or out_valid_o within the same cycle.
  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  // State and payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state and payload steering
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush_i) begin
      // A flush wins over any handshake. A payload that the upstream stage
      // offers in this cycle is dropped, even when in_ready_o reads 1.
      state_d = ST_EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = in_data_i;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            // Downstream stalled: park the new payload and keep main stable.
            state_d = ST_FULL;
            skid_d  = in_data_i;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready_o is low here, so only the drain path can happen.
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Output decode from registered state only
  always_comb begin
    out_valid_o = 1'b0;
    in_ready_o  = 1'b1;
    occupancy_o = 2'd0;
    unique case (state_q)
      ST_EMPTY: begin
        out_valid_o = 1'b0;
        in_ready_o  = 1'b1;
        occupancy_o = 2'd0;
      end
      ST_ONE: begin
        out_valid_o = 1'b1;
        in_ready_o  = 1'b1;
        occupancy_o = 2'd1;
      end
      ST_FULL: begin
        out_valid_o = 1'b1;
        in_ready_o  = 1'b0;
        occupancy_o = 2'd2;
      end
      default: begin
        out_valid_o = 1'b0;
        in_ready_o  = 1'b1;
        occupancy_o = 2'd0;
      end
    endcase
  end

  assign out_data_o = main_q;

endmodule
